req_arbiter4: RTL and testbench

- Four-requester arbiter that grants a single shared resource to one requester at a time.
- Resource examples: the shared encoder output bus or a downstream register port.
- Selection is either fixed priority (req[3] highest down to req[0] lowest, same ordering as the team's priority encoder) or round-robin.
- Grants are registered and held until the owner releases or a hold timeout expires. Sits between requesting blocks and the shared datapath.

---
 rtl/req_arbiter4_if.sv | 14 +
 rtl/req_arbiter4.sv | 108 ++++++++++
 tb/tb_req_arbiter4.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/req_arbiter4_if.sv
// Handshake bundle between the requesting blocks and the 4-way arbiter.
// The requester side drives mode/req/rel; the arbiter drives the grant signals.
interface req_arbiter4_if;
  logic       mode;
  logic [3:0] req;
  logic       rel;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (output mode, req, rel, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input mode, req, rel, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/req_arbiter4.sv
// Four-requester arbiter, fixed-priority or round-robin, with registered grants
// held until release, owner request drop, or a MAX_HOLD-cycle forced release.
module req_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  req_arbiter4_if.slave bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_nx;
  logic [NUM_LANES-1:0] gnt_q, gnt_nx;
  logic [1:0]           id_q, id_nx;
  logic [1:0]           last_id, last_nx;
  logic                 vld_q, vld_nx;
  logic                 to_q, to_nx;
  logic [CNT_W-1:0]     hold_cnt, cnt_nx;
  logic [1:0]           fp_id, rr_id, win;
  logic [1:0]           idx;
  logic                 at_max, owner_req, release_c;

  // Fixed priority: ascending overwrite leaves the highest set index.
  // Round-robin: descending offset overwrite leaves the first set index after last_id.
  always_comb begin
    fp_id = 2'd0;
    rr_id = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < NUM_LANES; i++)
      if (bus.req[i]) fp_id = 2'(i);
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = last_id + 2'(k);
      if (bus.req[idx]) rr_id = idx;
    end
    win = bus.mode ? rr_id : fp_id;
  end

  assign at_max    = (hold_cnt == CNT_W'(MAX_HOLD));
  assign owner_req = bus.req[id_q];
  assign release_c = bus.rel || !owner_req || at_max;

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_q;
    id_nx    = id_q;
    vld_nx   = vld_q;
    cnt_nx   = hold_cnt;
    last_nx  = last_id;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nx = GRANT;
          gnt_nx   = 4'b0001 << win;
          id_nx    = win;
          vld_nx   = 1'b1;
          cnt_nx   = CNT_W'(1);
          last_nx  = win;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          id_nx    = 2'd0;
          vld_nx   = 1'b0;
          cnt_nx   = '0;
          // Forced release flags timeout only when nothing else explains the drop.
          to_nx    = !bus.rel && owner_req;
        end else if (!at_max) begin
          cnt_nx = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      id_q     <= 2'd0;
      vld_q    <= 1'b0;
      to_q     <= 1'b0;
      hold_cnt <= '0;
      last_id  <= 2'd3;
    end else begin
      gnt_q    <= gnt_nx;
      id_q     <= id_nx;
      vld_q    <= vld_nx;
      to_q     <= to_nx;
      hold_cnt <= cnt_nx;
      last_id  <= last_nx;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = vld_q;
  assign bus.timeout   = to_q;
endmodule

// File: tb/tb_req_arbiter4.sv
// Bench for req_arbiter4: directed vector table, hand sequences for multi-cycle
// corners, and random traffic compared against a behavioural owner/hold model.
module tb_req_arbiter4;
  localparam int MAX_HOLD = 8;

  logic clk, rst_n;
  int   checks = 0, errors = 0;

  req_arbiter4_if bus ();

  req_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: owner index (-1 = nobody), cycles held, last winner, timeout flag.
  int m_owner, m_hold, m_last;
  bit m_to;

  function automatic int pick(input logic md, input logic [3:0] r, input int last);
    int w;
    w = -1;
    if (!md) begin
      for (int i = 0; i < 4; i++) if (r[i]) w = i;
    end else begin
      for (int k = 4; k >= 1; k--) if (r[(last + k) % 4]) w = (last + k) % 4;
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_hold = 0; m_last = 3; m_to = 0;
    end else begin
      m_to = 0;
      if (m_owner < 0) begin
        if (bus.req != 4'b0) begin
          m_owner = pick(bus.mode, bus.req, m_last);
          m_last  = m_owner;
          m_hold  = 1;
        end
      end else if (bus.rel || !bus.req[m_owner] || m_hold >= MAX_HOLD) begin
        m_to    = !bus.rel && bus.req[m_owner];
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end
  end

  task automatic model_cmp(input string nm);
    logic [3:0] eg;
    logic [1:0] eid;
    eg  = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    checks++;
    if (bus.gnt !== eg || bus.gnt_id !== eid || bus.gnt_valid !== (m_owner >= 0) || bus.timeout !== m_to) begin
      errors++;
      $display("FAIL model %s t=%0t: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b",
               nm, $time, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, eg, eid, m_owner >= 0, m_to);
    end
  endtask

  task automatic check_exp(input string nm, input logic [3:0] g, input logic [1:0] id,
                           input logic v, input logic t);
    checks++;
    if (bus.gnt !== g || bus.gnt_id !== id || bus.gnt_valid !== v || bus.timeout !== t) begin
      errors++;
      $display("FAIL %s t=%0t: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b",
               nm, $time, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, g, id, v, t);
    end
  endtask

  // Drive inputs just after a falling edge; results are sampled on the next falling edge.
  task automatic step(input logic md, input logic [3:0] r, input logic rl);
    bus.mode = md; bus.req = r; bus.rel = rl;
    @(negedge clk);
    model_cmp("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mode = 1'b0; bus.req = 4'b0; bus.rel = 1'b0;
    @(negedge clk);
    check_exp("reset_state", 4'b0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       mode;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'b1010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.mode = 1'b0; bus.req = 4'b0; bus.rel = 1'b0;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].mode, tbl[i].req, tbl[i].rel);
      check_exp($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].vld, tbl[i].to);
    end

    // Round-robin rotation from reset: 0,1,2,3,0 with a dead cycle between grants.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b1111, 1'b0);
      check_exp($sformatf("rr_grant%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
      step(1'b1, 4'b1111, 1'b1);
      check_exp($sformatf("rr_dead%0d", k), 4'b0, 2'd0, 1'b0, 1'b0);
    end

    // Hold timeout: exactly MAX_HOLD granted cycles, one timeout pulse, then regrant.
    step(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < MAX_HOLD; k++) begin
      step(1'b0, 4'b0100, 1'b0);
      check_exp($sformatf("hold%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step(1'b0, 4'b0100, 1'b0);
    check_exp("timeout_pulse", 4'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 4'b0100, 1'b0);
    check_exp("timeout_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b0, 4'b0100, 1'b1);
    check_exp("rel_no_timeout", 4'b0, 2'd0, 1'b0, 1'b0);

    // rel and hold limit on the same edge: a normal release, no timeout.
    for (int k = 0; k < MAX_HOLD; k++) step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b1);
    check_exp("rel_at_max", 4'b0, 2'd0, 1'b0, 1'b0);

    // Owner drops its request at cycle 3.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    check_exp("drop_held", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check_exp("drop_release", 4'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    check_exp("rel_in_idle", 4'b0, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-grant, then round-robin restarts at index 0.
    step(1'b0, 4'b0010, 1'b0);
    check_exp("pre_async", 4'b0010, 2'd1, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_exp("async_rst", 4'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'b1001, 1'b0);
    check_exp("post_rst_rr", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Mode toggled during a grant applies only at the next arbitration.
    do_reset();
    step(1'b0, 4'b1001, 1'b0);
    check_exp("toggle_fp", 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b1001, 1'b0);
    check_exp("toggle_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b1, 4'b1001, 1'b1);
    step(1'b1, 4'b1001, 1'b0);
    check_exp("toggle_rr", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Random traffic against the model; rel kept sparse so timeouts occur.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0 && m_owner >= 0) r[m_owner] = 1'b1;
      step(1'($urandom_range(0, 1)), r, ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
